// File: rtl/vga_sync_gen_pkg.sv
// vga_timing_pkg: default VGA 640x480@60 raster constants, colour type and
// small helpers shared by the sync generator, its interface and sub-blocks.
package vga_timing_pkg;

  localparam int COLOR_W = 3;
  localparam int CNT_W   = 10;

  typedef logic [COLOR_W-1:0] rgb_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam rgb_t RGB_BLACK = 3'b000;
  localparam rgb_t RGB_WHITE = 3'b111;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // True when pos lies in the inclusive window [first, last].
  function automatic logic in_window(cnt_t pos, cnt_t first, cnt_t last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel coordinate / colour bus between the timing generator
// (master) and the renderer plus display pins (slave).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  rgb_t rgb_in;
  cnt_t x;
  cnt_t y;
  logic video_on;
  logic p_tick;
  logic line_tick;
  logic frame_tick;
  logic hsync;
  logic vsync;
  rgb_t rgb_out;

  modport master (
    input  rgb_in,
    output x, y, video_on, p_tick, line_tick, frame_tick, hsync, vsync, rgb_out
  );

  modport slave (
    output rgb_in,
    input  x, y, video_on, p_tick, line_tick, frame_tick, hsync, vsync, rgb_out
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to the pixel rate and emits a
// one-clock enable on the last system clock of every pixel period.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running modulo-CLK_DIV counter; restarts at 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator. Scans the horizontal/vertical
// counters at the pixel rate, publishes the coordinate bus to the renderer and
// re-times sync and blanked colour so that all three pins move together one
// pixel behind the coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
  localparam cnt_t HS_FIRST = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t HS_LAST  = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t VS_LAST  = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic p_tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_end;
  logic v_end;
  logic video_on;
  logic hsync_raw;
  logic vsync_raw;
  logic hsync_q;
  logic vsync_q;
  rgb_t rgb_q;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .p_tick (p_tick)
  );

  // Decode the end-of-line/frame positions, visible area and raw sync windows.
  always_comb begin
    h_end     = (h_cnt == H_LAST);
    v_end     = (v_cnt == V_LAST);
    video_on  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_raw = !in_window(h_cnt, HS_FIRST, HS_LAST);
    vsync_raw = !in_window(v_cnt, VS_FIRST, VS_LAST);
  end

  // Raster scan: x advances each pixel, y advances only when x wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (p_tick) begin
      if (h_end) begin
        h_cnt <= '0;
        if (v_end) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pin stage: capture sync and blanked colour once per pixel so all three
  // outputs lag the coordinates by exactly one pixel period together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= RGB_BLACK;
    end else if (p_tick) begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      rgb_q   <= video_on ? bus.rgb_in : RGB_BLACK;
    end
  end

  assign bus.x          = h_cnt;
  assign bus.y          = v_cnt;
  assign bus.video_on   = video_on;
  assign bus.p_tick     = p_tick;
  assign bus.line_tick  = p_tick && h_end;
  assign bus.frame_tick = p_tick && h_end && v_end;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen on a shrunken raster (32 x 17 pixels)
// against hand-computed snapshots and an arithmetic model that derives every
// output from the number of clocks elapsed since reset.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int D  = 2;
  localparam int HD = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int VD = 10;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * D;

  typedef struct {
    int k;
    int x;
    int y;
    int pt;
    int lt;
    int ft;
    int hs;
    int vs;
    int rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vga_sync_gen_if bus();

  int errors = 0;
  int checks = 0;
  int k = 0;
  int lastRgb = 0;
  rgb_t curRgb = '0;
  vec_t vecs[19];

  vga_sync_gen #(
    .CLK_DIV   (D),
    .H_DISPLAY (HD),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_DISPLAY (VD),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (clocks since reset=%0d)", name, act, exp, k);
    end
  endtask

  task automatic applyStimulus(input logic r, input rgb_t c);
    rst        = r;
    curRgb     = c;
    bus.rgb_in = c;
  endtask

  // One clock; the model tracks clocks since reset and the colour the DUT
  // captured on the most recent pixel boundary.
  task automatic stepClock();
    @(posedge clk);
    if (rst) begin
      k = 0;
    end else begin
      k++;
      if (k % D == 0) lastRgb = int'(curRgb);
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int p, h, v, q, hq, vq;
    int ePt, eLt, eFt, eVo, eHs, eVs, eRgb;
    p   = k / D;
    h   = p % HT;
    v   = (p / HT) % VT;
    ePt = (k % D == D - 1) ? 1 : 0;
    eLt = (ePt == 1 && h == HT - 1) ? 1 : 0;
    eFt = (eLt == 1 && v == VT - 1) ? 1 : 0;
    eVo = (h < HD && v < VD) ? 1 : 0;
    if (p == 0) begin
      eHs  = 1;
      eVs  = 1;
      eRgb = 0;
    end else begin
      q    = p - 1;
      hq   = q % HT;
      vq   = (q / HT) % VT;
      eHs  = (hq >= HD + HF && hq < HD + HF + HS) ? 0 : 1;
      eVs  = (vq >= VD + VF && vq < VD + VF + VS) ? 0 : 1;
      eRgb = (hq < HD && vq < VD) ? lastRgb : 0;
    end
    cmp({tag, " x"},          int'(bus.x),          h);
    cmp({tag, " y"},          int'(bus.y),          v);
    cmp({tag, " video_on"},   int'(bus.video_on),   eVo);
    cmp({tag, " p_tick"},     int'(bus.p_tick),     ePt);
    cmp({tag, " line_tick"},  int'(bus.line_tick),  eLt);
    cmp({tag, " frame_tick"}, int'(bus.frame_tick), eFt);
    cmp({tag, " hsync"},      int'(bus.hsync),      eHs);
    cmp({tag, " vsync"},      int'(bus.vsync),      eVs);
    cmp({tag, " rgb_out"},    int'(bus.rgb_out),    eRgb);
  endtask

  initial begin
    int guard, n, lastLt, lastFt, hsLow, vsLow, frameIdx;
    rgb_t rgbNext;

    // Snapshots with rgb_in held white: {clocks since reset, x, y, p_tick,
    // line_tick, frame_tick, hsync, vsync, rgb_out}.
    vecs[0]  = '{0,    0,  0,  0, 0, 0, 1, 1, 0};
    vecs[1]  = '{1,    0,  0,  1, 0, 0, 1, 1, 0};
    vecs[2]  = '{2,    1,  0,  0, 0, 0, 1, 1, 7};
    vecs[3]  = '{32,   16, 0,  0, 0, 0, 1, 1, 7};
    vecs[4]  = '{34,   17, 0,  0, 0, 0, 1, 1, 0};
    vecs[5]  = '{40,   20, 0,  0, 0, 0, 1, 1, 0};
    vecs[6]  = '{42,   21, 0,  0, 0, 0, 0, 1, 0};
    vecs[7]  = '{52,   26, 0,  0, 0, 0, 0, 1, 0};
    vecs[8]  = '{54,   27, 0,  0, 0, 0, 1, 1, 0};
    vecs[9]  = '{63,   31, 0,  1, 1, 0, 1, 1, 0};
    vecs[10] = '{64,   0,  1,  0, 0, 0, 1, 1, 0};
    vecs[11] = '{66,   1,  1,  0, 0, 0, 1, 1, 7};
    vecs[12] = '{768,  0,  12, 0, 0, 0, 1, 1, 0};
    vecs[13] = '{770,  1,  12, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{834,  1,  13, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{898,  1,  14, 0, 0, 0, 1, 1, 0};
    vecs[16] = '{1087, 31, 16, 1, 1, 1, 1, 1, 0};
    vecs[17] = '{1088, 0,  0,  0, 0, 0, 1, 1, 0};
    vecs[18] = '{1090, 1,  0,  0, 0, 0, 1, 1, 7};

    $display("[TB] reset and snapshot table");
    applyStimulus(1'b1, RGB_WHITE);
    stepClock();
    applyStimulus(1'b0, RGB_WHITE);
    for (int i = 0; i < 19; i++) begin
      guard = 0;
      while (k < vecs[i].k && guard < 2 * FRAME_CLKS) begin
        stepClock();
        checkOutput("white");
        guard++;
      end
      cmp($sformatf("vec%0d clocks", i), k,                     vecs[i].k);
      cmp($sformatf("vec%0d x", i),      int'(bus.x),          vecs[i].x);
      cmp($sformatf("vec%0d y", i),      int'(bus.y),          vecs[i].y);
      cmp($sformatf("vec%0d p_tick", i), int'(bus.p_tick),     vecs[i].pt);
      cmp($sformatf("vec%0d line", i),   int'(bus.line_tick),  vecs[i].lt);
      cmp($sformatf("vec%0d frame", i),  int'(bus.frame_tick), vecs[i].ft);
      cmp($sformatf("vec%0d hsync", i),  int'(bus.hsync),      vecs[i].hs);
      cmp($sformatf("vec%0d vsync", i),  int'(bus.vsync),      vecs[i].vs);
      cmp($sformatf("vec%0d rgb", i),    int'(bus.rgb_out),    vecs[i].rgb);
    end

    $display("[TB] reset inside hsync");
    guard = 0;
    while (!(bus.x == 10'd22 && bus.y == 10'd6) && guard < 3 * FRAME_CLKS) begin
      stepClock();
      checkOutput("seek");
      guard++;
    end
    cmp("seek x=22 y=6 within budget", (guard < 3 * FRAME_CLKS) ? 1 : 0, 1);
    cmp("hsync low before reset", int'(bus.hsync), 0);
    applyStimulus(1'b1, RGB_WHITE);
    stepClock();
    cmp("after reset hsync", int'(bus.hsync),   1);
    cmp("after reset x",     int'(bus.x),       0);
    cmp("after reset y",     int'(bus.y),       0);
    cmp("after reset rgb",   int'(bus.rgb_out), 0);
    checkOutput("reset");
    applyStimulus(1'b0, RGB_WHITE);
    n = 1;
    while (!bus.p_tick && n < 20) begin
      stepClock();
      checkOutput("restart");
      n++;
    end
    cmp("clocks to first p_tick", n, D);

    $display("[TB] randomized frames against model");
    lastLt = -1;
    lastFt = -1;
    hsLow  = 0;
    vsLow  = 0;
    for (int c = 0; c < 3 * FRAME_CLKS; c++) begin
      frameIdx = c / FRAME_CLKS;
      if (frameIdx < 2) rgbNext = rgb_t'($urandom_range(0, 7));
      else rgbNext = bus.x[2:0];
      applyStimulus(1'b0, rgbNext);
      stepClock();
      checkOutput("rand");
      if (bus.line_tick) begin
        if (lastLt >= 0) cmp("line_tick period", c - lastLt, HT * D);
        lastLt = c;
      end
      if (bus.frame_tick) begin
        if (lastFt >= 0) cmp("frame_tick period", c - lastFt, FRAME_CLKS);
        lastFt = c;
      end
      if (!bus.hsync) hsLow++;
      else if (hsLow > 0) begin
        cmp("hsync low clocks", hsLow, HS * D);
        hsLow = 0;
      end
      if (!bus.vsync) vsLow++;
      else if (vsLow > 0) begin
        cmp("vsync low clocks", vsLow, VS * HT * D);
        vsLow = 0;
      end
    end
    cmp("frame_tick seen", (lastFt >= 0) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
